// File: rtl/snow64_vector_mul_div_dispatcher_pkg.sv
// Shared types for the vector mul/div dispatcher: unit command and
// response bundles, dispatcher state and timeout counter width.
package snow64_vector_mul_div_dispatcher_pkg;

  localparam int MSB_POS__SNOW64_LAR_FILE_DATA = 255;
  localparam int WIDTH__VEC = MSB_POS__SNOW64_LAR_FILE_DATA + 1;
  localparam int DISP_TIMEOUT_CYCLES = 255;
  localparam int WIDTH__DISP_TIMEOUT_COUNTER =
    $clog2(DISP_TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssueMul,
    StWaitMul,
    StIssueDiv,
    StWaitDiv,
    StHold
  } DispState;

  typedef struct packed {
    logic                  enable;
    logic [1:0]            int_type_size;
    logic [WIDTH__VEC-1:0] a;
    logic [WIDTH__VEC-1:0] b;
  } PortIn_VectorMul;

  typedef struct packed {
    logic                  valid;
    logic [WIDTH__VEC-1:0] data;
  } PortOut_VectorMul;

  typedef struct packed {
    logic                  enable;
    logic [1:0]            int_type_size;
    logic                  type_signedness;
    logic [WIDTH__VEC-1:0] a;
    logic [WIDTH__VEC-1:0] b;
  } PortIn_VectorDiv;

  typedef struct packed {
    logic                  valid;
    logic [WIDTH__VEC-1:0] data;
  } PortOut_VectorDiv;

endpackage

// File: rtl/snow64_dispatch_timeout_counter.sv
// Saturating wait-cycle counter; expired_o marks the last allowed
// wait cycle so the FSM can force completion on that edge.
module snow64_dispatch_timeout_counter #(
  parameter int unsigned MAX = 255,
  localparam int unsigned W = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic incr_i,
  output logic expired_o
);

  localparam logic [W-1:0] MaxV  = W'(MAX);
  localparam logic [W-1:0] LastV = W'(MAX - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (incr_i && (cnt_q != MaxV)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q >= LastV);

endmodule

// File: rtl/snow64_vector_mul_div_dispatcher.sv
// Issues one vector mul/div command, waits for the unit's result or a
// timeout, and holds it for writeback under valid/ready.
module snow64_vector_mul_div_dispatcher
  import snow64_vector_mul_div_dispatcher_pkg::*;
#(
  parameter int DATA_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_div,
  input  logic [1:0]            in_int_type_size,
  input  logic                  in_type_signedness,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output PortIn_VectorMul       to_mul,
  input  PortOut_VectorMul      from_mul,
  output PortIn_VectorDiv       to_div,
  input  PortOut_VectorDiv      from_div,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_timeout
);

  DispState              state_q;
  logic                  in_ready_q;
  logic                  mul_en_q;
  logic                  div_en_q;
  logic                  out_valid_q;
  logic                  out_timeout_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [1:0]            size_q;
  logic                  sgn_q;

  logic tmo_clear;
  logic tmo_incr;
  logic tmo_expired;

  assign tmo_clear = (state_q == StIdle);
  assign tmo_incr  = (state_q == StWaitMul) ||
                     (state_q == StWaitDiv);

  snow64_dispatch_timeout_counter #(
    .MAX(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tmo_clear),
    .incr_i   (tmo_incr),
    .expired_o(tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      in_ready_q    <= 1'b1;
      mul_en_q      <= 1'b0;
      div_en_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_timeout_q <= 1'b0;
      out_data_q    <= '0;
      a_q           <= '0;
      b_q           <= '0;
      size_q        <= '0;
      sgn_q         <= 1'b0;
    end else begin
      mul_en_q <= 1'b0;
      div_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            size_q     <= in_int_type_size;
            sgn_q      <= in_type_signedness;
            in_ready_q <= 1'b0;
            if (in_is_div) begin
              state_q  <= StIssueDiv;
              div_en_q <= 1'b1;
            end else begin
              state_q  <= StIssueMul;
              mul_en_q <= 1'b1;
            end
          end
        end
        StIssueMul: state_q <= StWaitMul;
        StIssueDiv: state_q <= StWaitDiv;
        // Only the selected unit's valid is looked at here.
        StWaitMul: begin
          if (from_mul.valid) begin
            out_data_q    <= from_mul.data;
            out_timeout_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state_q       <= StHold;
          end else if (tmo_expired) begin
            out_data_q    <= '0;
            out_timeout_q <= 1'b1;
            out_valid_q   <= 1'b1;
            state_q       <= StHold;
          end
        end
        StWaitDiv: begin
          if (from_div.valid) begin
            out_data_q    <= from_div.data;
            out_timeout_q <= 1'b0;
            out_valid_q   <= 1'b1;
            state_q       <= StHold;
          end else if (tmo_expired) begin
            out_data_q    <= '0;
            out_timeout_q <= 1'b1;
            out_valid_q   <= 1'b1;
            state_q       <= StHold;
          end
        end
        StHold: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign to_mul = '{
    enable:        mul_en_q,
    int_type_size: size_q,
    a:             a_q,
    b:             b_q
  };

  assign to_div = '{
    enable:          div_en_q,
    int_type_size:   size_q,
    type_signedness: sgn_q,
    a:               a_q,
    b:               b_q
  };

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_timeout = out_timeout_q;

endmodule

// File: tb/tb_snow64_vector_mul_div_dispatcher.sv
// Bench for the vector mul/div dispatcher with behavioural
// multiplier/divider models and a result scoreboard.
module tb_snow64_vector_mul_div_dispatcher;
  import snow64_vector_mul_div_dispatcher_pkg::*;

  localparam int TMO = 16;

  typedef struct {
    bit           is_div;
    logic [1:0]   size;
    bit           sgn;
    logic [255:0] a;
    logic [255:0] b;
    int           lat;
    logic [255:0] exp_data;
    bit           exp_tmo;
  } vec_t;

  typedef struct {
    logic [255:0] data;
    bit           tmo;
  } exp_t;

  logic         clk = 0;
  logic         rst = 0;
  logic         in_valid = 0;
  logic         in_ready;
  logic         in_is_div = 0;
  logic [1:0]   in_int_type_size = '0;
  logic         in_type_signedness = 0;
  logic [255:0] in_a = '0;
  logic [255:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 0;
  logic [255:0] out_data;
  logic         out_timeout;

  PortIn_VectorMul  to_mul;
  PortOut_VectorMul from_mul = '0;
  PortIn_VectorDiv  to_div;
  PortOut_VectorDiv from_div = '0;

  int passed = 0;
  int total = 0;
  exp_t sb[$];

  int mul_lat = 0;
  int div_lat = 0;
  int mul_cnt = 0;
  int div_cnt = 0;
  int mul_en_cnt = 0;
  int div_en_cnt = 0;
  int en_run_err = 0;
  logic prev_mul_en = 0;
  logic prev_div_en = 0;
  logic [255:0] mul_res = '0;
  logic [255:0] div_res = '0;
  logic inj_div = 0;
  bit hold_req = 0;
  vec_t hold_vec;
  vec_t tbl[8];

  snow64_vector_mul_div_dispatcher #(
    .DATA_WIDTH(256),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_is_div(in_is_div),
    .in_int_type_size(in_int_type_size),
    .in_type_signedness(in_type_signedness),
    .in_a(in_a),
    .in_b(in_b),
    .to_mul(to_mul),
    .from_mul(from_mul),
    .to_div(to_div),
    .from_div(from_div),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_timeout(out_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] lane_op(
    input logic [255:0] a, input logic [255:0] b,
    input logic [1:0] size, input bit is_div, input bit sgn);
    int w;
    int n;
    logic [63:0] mask, x, y, r;
    logic [255:0] res;
    w = 8 << size;
    n = 256 / w;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    res = '0;
    for (int i = 0; i < n; i++) begin
      x = 64'(a >> (i * w)) & mask;
      y = 64'(b >> (i * w)) & mask;
      if (is_div) begin
        if (sgn) begin
          x = $signed(x << (64 - w)) >>> (64 - w);
          y = $signed(y << (64 - w)) >>> (64 - w);
          r = $signed(x) / $signed(y);
        end else begin
          r = x / y;
        end
      end else begin
        r = x * y;
      end
      res = res | (256'(r & mask) << (i * w));
    end
    return res;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic vec_t mkvec(input bit d, input logic [1:0] s,
                                 input bit g, input int lat);
    vec_t v;
    v.is_div = d;
    v.size = s;
    v.sgn = g;
    v.a = rnd256();
    v.b = rnd256() | {32{8'h01}};
    v.lat = lat;
    v.exp_data = lane_op(v.a, v.b, s, d, g);
    v.exp_tmo = 0;
    return v;
  endfunction

  // Multiplier / divider behavioural models.
  always @(posedge clk) begin
    from_mul.valid <= 1'b0;
    if (mul_cnt == 1) begin
      from_mul.valid <= 1'b1;
      from_mul.data <= mul_res;
    end
    if (mul_cnt > 0) mul_cnt <= mul_cnt - 1;
    if (to_mul.enable && mul_lat > 0) begin
      mul_cnt <= mul_lat;
      mul_res <= lane_op(to_mul.a, to_mul.b, to_mul.int_type_size,
                         1'b0, 1'b0);
    end
    from_div.valid <= 1'b0;
    if (div_cnt == 1) begin
      from_div.valid <= 1'b1;
      from_div.data <= div_res;
    end
    if (div_cnt > 0) div_cnt <= div_cnt - 1;
    if (to_div.enable && div_lat > 0) begin
      div_cnt <= div_lat;
      div_res <= lane_op(to_div.a, to_div.b, to_div.int_type_size,
                         1'b1, to_div.type_signedness);
    end
    if (inj_div) begin
      from_div.valid <= 1'b1;
      from_div.data <= {8{32'hA5A5_5A5A}};
    end
  end

  always @(posedge clk) begin
    prev_mul_en <= to_mul.enable;
    prev_div_en <= to_div.enable;
    if (to_mul.enable) mul_en_cnt <= mul_en_cnt + 1;
    if (to_div.enable) div_en_cnt <= div_en_cnt + 1;
    if ((to_mul.enable && prev_mul_en) || (to_div.enable && prev_div_en))
      en_run_err <= en_run_err + 1;
  end

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1;
    in_is_div = v.is_div;
    in_int_type_size = v.size;
    in_type_signedness = v.sgn;
    in_a = v.a;
    in_b = v.b;
    mul_lat = v.is_div ? 0 : v.lat;
    div_lat = v.is_div ? v.lat : 0;
  endtask

  task automatic run_vec(input vec_t v, input int hold, input int inj_at);
    int k, n, m0, d0, exp_lat;
    bit got, stable, ops_ok;
    logic [255:0] d;
    exp_t e;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("in_ready before request", 256'(in_ready), 256'(1));
    m0 = mul_en_cnt;
    d0 = div_en_cnt;
    drive(v);
    sb.push_back('{v.exp_data, v.exp_tmo});
    n = 0;
    got = 0;
    while (!got && n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      in_valid = 0;
      inj_div = (n == inj_at);
      if (n == 1) begin
        if (v.is_div) begin
          check("div issue ctrl",
                256'({to_div.enable, to_div.type_signedness,
                      to_div.int_type_size, to_mul.enable}),
                256'({1'b1, v.sgn, v.size, 1'b0}));
          ops_ok = (to_div.a === v.a) && (to_div.b === v.b);
        end else begin
          check("mul issue ctrl",
                256'({to_mul.enable, to_mul.int_type_size, to_div.enable}),
                256'({1'b1, v.size, 1'b0}));
          ops_ok = (to_mul.a === v.a) && (to_mul.b === v.b);
        end
        check("issue operands", 256'(ops_ok), 256'(1));
      end
      if (out_valid === 1'b1) got = 1;
    end
    check("out_valid arrives", 256'(got), 256'(1));
    exp_lat = (v.lat == 0) ? TMO + 2 : 3 + v.lat;
    check("latency", 256'(n), 256'(exp_lat));
    if (sb.size() == 0) begin
      total++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check("out_data", out_data, e.data);
      check("out_timeout", 256'(out_timeout), 256'(e.tmo));
    end
    check("mul enables", 256'(mul_en_cnt - m0), 256'(v.is_div ? 0 : 1));
    check("div enables", 256'(div_en_cnt - d0), 256'(v.is_div ? 1 : 0));
    d = out_data;
    stable = 1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      inj_div = (n == inj_at);
      if (hold_req) drive(hold_vec);
      if (out_valid !== 1'b1 || out_data !== d || in_ready !== 1'b0)
        stable = 0;
    end
    if (hold > 0) check("hold stable", 256'(stable), 256'(1));
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    inj_div = 0;
    check("handshake", 256'({out_valid, in_ready}), 256'(2'b01));
    check("single enable",
          256'(mul_en_cnt + div_en_cnt - m0 - d0), 256'(1));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t sv;
    bit saw;
    tbl[0] = '{1'b0, 2'd0, 1'b0, {32{8'h03}}, {32{8'h05}}, 4,
               {32{8'h0F}}, 1'b0};
    tbl[1] = '{1'b1, 2'd3, 1'b1, {4{64'hFFFF_FFFF_FFFF_FFF6}},
               {4{64'd2}}, 6, {4{64'hFFFF_FFFF_FFFF_FFFB}}, 1'b0};
    tbl[2] = mkvec(1'b0, 2'd1, 1'b0, 1);
    tbl[3] = mkvec(1'b0, 2'd2, 1'b0, 2);
    tbl[4] = mkvec(1'b0, 2'd3, 1'b0, 3);
    tbl[5] = mkvec(1'b1, 2'd0, 1'b0, 5);
    tbl[6] = mkvec(1'b1, 2'd1, 1'b1, 2);
    tbl[7] = mkvec(1'b1, 2'd2, 1'b1, 1);

    #1 rst = 1;
    @(negedge clk);
    check("reset outputs",
          256'({in_ready, out_valid, out_timeout}), 256'(3'b100));
    check("reset out_data", out_data, '0);
    check("reset to_mul", 256'(to_mul == '0), 256'(1));
    check("reset to_div", 256'(to_div == '0), 256'(1));
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], 0, -1);

    // Divider that never answers, late valid landing in Hold.
    sv = mkvec(1'b1, 2'd3, 1'b1, 0);
    sv.exp_data = '0;
    sv.exp_tmo = 1;
    run_vec(sv, 8, 20);

    // Writeback stalls with a second request already waiting.
    hold_vec = tbl[3];
    hold_req = 1;
    run_vec(tbl[2], 10, -1);
    hold_req = 0;
    run_vec(tbl[3], 0, -1);

    // Reset while waiting on the multiplier, stray valid afterwards.
    sv = tbl[0];
    sv.lat = 8;
    drive(sv);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    check("mid-op reset ctrl",
          256'({out_valid, in_ready, out_timeout,
                to_mul.enable, to_div.enable}), 256'(5'b01000));
    check("mid-op reset data", out_data, '0);
    @(negedge clk);
    rst = 0;
    saw = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) saw = 1;
    end
    check("stray valid ignored", 256'(saw), 256'(0));

    // Spurious divider valid during a multiply.
    sv = tbl[2];
    sv.lat = 5;
    run_vec(sv, 0, 2);

    check("enable one cycle", 256'(en_run_err), 256'(0));
    check("scoreboard drained", 256'(sb.size()), 256'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
